transpose_buf2dat: RTL

- Drain side of the transpose path: reads completed tiles out of the transpose buffer and streams them to the MCIF write channel as AXI-style bursts.
- Issues one write command (address, length) per burst, then exactly that many data beats.
- Sits between the transpose buffer (tile-ready/release handshake, 1-cycle read latency) and the MCIF write command/data FIFOs.

---
 rtl/transpose_buf2dat.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/transpose_buf2dat.sv
// -----------------------------------------------------------------------------
// transpose_buf2dat
//   Drain side of the transpose path. Walks every (channel group, burst) pair of
//   a job. For each pair it waits for a filled tile in the transpose buffer,
//   issues one write command, then reads the tile out in address order and
//   streams it as that burst's data beats. The tile is released when its last
//   beat has been accepted.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 one-cycle pulse in IDLE: latch config, begin job
//   base_addr             byte address of output surface 0
//   surface_stride        byte offset between channel groups
//   ch_out_div_tout       number of channel groups (>=1)
//   w_out                 output pixels per channel group (>=1)
//   buf_vld               a filled tile is available (sampled in WAIT_BUF only)
//   buf_release           pulse: current tile fully drained
//   buf_rd_en/_addr       buffer read strobe / address
//   buf_rd_dat            read data, valid one cycle after buf_rd_en
//   cmd_vld/rdy/addr/len_minus1   write command channel
//   dat_vld/rdy/pd        write data channel
//   busy                  job in progress
//   done                  pulse in the cycle after the job's last beat
// -----------------------------------------------------------------------------
module transpose_buf2dat #(
  parameter int DAT_W      = 256,
  parameter int BURST_LEN  = 8,
  parameter int LOG2_BURST = 3,
  parameter int BUF_AW     = 5,
  parameter int CH_W       = 8,
  parameter int W_W        = 12,
  parameter int ADDR_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W-1:0]     surface_stride,
  input  logic [CH_W-1:0]       ch_out_div_tout,
  input  logic [W_W-1:0]        w_out,
  input  logic                  buf_vld,
  output logic                  buf_release,
  output logic                  buf_rd_en,
  output logic [BUF_AW-1:0]     buf_rd_addr,
  input  logic [DAT_W-1:0]      buf_rd_dat,
  output logic                  cmd_vld,
  input  logic                  cmd_rdy,
  output logic [ADDR_W-1:0]     cmd_addr,
  output logic [LOG2_BURST-1:0] cmd_len_minus1,
  output logic                  dat_vld,
  input  logic                  dat_rdy,
  output logic [DAT_W-1:0]      dat_pd,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_W-1:0]     BURST_BYTES = ADDR_W'(BURST_LEN * (DAT_W / 8));
  localparam logic [LOG2_BURST-1:0] FULL_LEN_M1 = {LOG2_BURST{1'b1}};
  localparam logic [LOG2_BURST:0]   RD_ONE      = (LOG2_BURST+1)'(1);
  localparam logic [LOG2_BURST-1:0] BEAT_ONE    = LOG2_BURST'(1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_BUF, S_CMD, S_DATA} state_t;

  state_t                state_reg;
  logic [ADDR_W-1:0]     stride_reg;
  logic [ADDR_W-1:0]     grp_addr_reg;    // base + ch_idx*stride
  logic [ADDR_W-1:0]     cmd_addr_reg;
  logic [LOG2_BURST-1:0] cmd_len_reg;
  logic                  cmd_vld_reg;
  logic [CH_W-1:0]       ch_last_reg;
  logic [CH_W-1:0]       ch_idx_reg;
  logic [W_W-1:0]        w_m1_reg;        // w_out - 1
  logic [W_W-1:0]        burst_idx_reg;
  logic [LOG2_BURST:0]   rd_cnt_reg;      // reads issued in current burst
  logic [LOG2_BURST-1:0] beat_cnt_reg;    // beats accepted in current burst
  logic                  busy_reg;
  logic                  done_reg;

  // 2-entry skid FIFO between the buffer read port and the data channel
  logic [DAT_W-1:0]      skid_mem [2];
  logic                  wr_ptr_reg;
  logic                  rd_ptr_reg;
  logic [1:0]            fifo_cnt_reg;
  logic                  rd_pend_reg;     // read issued last cycle, data arrives now

  logic [1:0]            occupancy;
  logic                  pop;
  logic                  last_beat;
  logic                  last_burst;
  logic                  last_grp;

  // w_out-1 gives both the index of the last burst (upper bits) and the last
  // burst's length-1 (lower bits); a zero remainder naturally maps to a full burst.
  assign last_burst = (burst_idx_reg == (w_m1_reg >> LOG2_BURST));
  assign last_grp   = (ch_idx_reg == ch_last_reg);

  assign occupancy  = fifo_cnt_reg + {1'b0, rd_pend_reg};
  assign dat_vld    = (fifo_cnt_reg != 2'd0);
  assign dat_pd     = skid_mem[rd_ptr_reg];
  assign pop        = dat_vld & dat_rdy;
  assign last_beat  = (state_reg == S_DATA) && pop && (beat_cnt_reg == cmd_len_reg);

  assign buf_rd_en   = (state_reg == S_DATA) && (occupancy < 2'd2) &&
                       (rd_cnt_reg <= {1'b0, cmd_len_reg});
  assign buf_rd_addr = BUF_AW'(rd_cnt_reg[LOG2_BURST-1:0]);
  assign buf_release = last_beat;

  assign cmd_vld        = cmd_vld_reg;
  assign cmd_addr       = cmd_addr_reg;
  assign cmd_len_minus1 = cmd_len_reg;
  assign busy           = busy_reg;
  assign done           = done_reg;

  // Control FSM and job counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      stride_reg    <= '0;
      grp_addr_reg  <= '0;
      cmd_addr_reg  <= '0;
      cmd_len_reg   <= '0;
      cmd_vld_reg   <= 1'b0;
      ch_last_reg   <= '0;
      ch_idx_reg    <= '0;
      w_m1_reg      <= '0;
      burst_idx_reg <= '0;
      rd_cnt_reg    <= '0;
      beat_cnt_reg  <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            stride_reg    <= surface_stride;
            grp_addr_reg  <= base_addr;
            cmd_addr_reg  <= base_addr;
            ch_last_reg   <= ch_out_div_tout - CH_W'(1);
            w_m1_reg      <= w_out - W_W'(1);
            ch_idx_reg    <= '0;
            burst_idx_reg <= '0;
            busy_reg      <= 1'b1;
            state_reg     <= S_WAIT_BUF;
          end
        end
        S_WAIT_BUF: begin
          if (buf_vld) begin
            cmd_vld_reg <= 1'b1;
            cmd_len_reg <= last_burst ? w_m1_reg[LOG2_BURST-1:0] : FULL_LEN_M1;
            state_reg   <= S_CMD;
          end
        end
        S_CMD: begin
          if (cmd_rdy) begin
            cmd_vld_reg  <= 1'b0;
            rd_cnt_reg   <= '0;
            beat_cnt_reg <= '0;
            state_reg    <= S_DATA;
          end
        end
        S_DATA: begin
          if (buf_rd_en) rd_cnt_reg <= rd_cnt_reg + RD_ONE;
          if (pop) beat_cnt_reg <= beat_cnt_reg + BEAT_ONE;
          if (last_beat) begin
            // Advance the address to the next burst now so the command
            // fields are ready the moment the next tile arrives.
            if (last_burst) begin
              burst_idx_reg <= '0;
              ch_idx_reg    <= ch_idx_reg + CH_W'(1);
              grp_addr_reg  <= grp_addr_reg + stride_reg;
              cmd_addr_reg  <= grp_addr_reg + stride_reg;
            end else begin
              burst_idx_reg <= burst_idx_reg + W_W'(1);
              cmd_addr_reg  <= cmd_addr_reg + BURST_BYTES;
            end
            if (last_burst && last_grp) begin
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              state_reg <= S_IDLE;
            end else begin
              state_reg <= S_WAIT_BUF;
            end
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // Skid FIFO: a read issued in cycle N lands here in cycle N+1. Push and pop
  // may happen in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) skid_mem[i] <= '0;
      wr_ptr_reg   <= 1'b0;
      rd_ptr_reg   <= 1'b0;
      fifo_cnt_reg <= 2'd0;
      rd_pend_reg  <= 1'b0;
    end else begin
      rd_pend_reg <= buf_rd_en;
      if (rd_pend_reg) begin
        skid_mem[wr_ptr_reg] <= buf_rd_dat;
        wr_ptr_reg           <= ~wr_ptr_reg;
      end
      if (pop) rd_ptr_reg <= ~rd_ptr_reg;
      fifo_cnt_reg <= fifo_cnt_reg + {1'b0, rd_pend_reg} - {1'b0, pop};
    end
  end

endmodule
